pipe_stage_elastic: RTL

- Parametrised, stallable and flushable pipeline stage register for the CPU datapath.
- Intended as the next-generation replacement for the fixed-width, always-enabled inter-stage registers.
- Carries a control bundle, register indices and a configurable number of 64-bit data words across a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput with registered in_ready. Flush inserts a bubble whose control bits are zero, so no memory or register-file write occurs.

---
 rtl/pipe_stage_elastic.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage register with optional 2-entry skid buffer.
// Flush squashes held entries and the current input beat; invalid heads present zero control.
module pipe_stage_elastic #(
  parameter int unsigned CTRL_W   = 4,
  parameter int unsigned NUM_REGS = 3,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_DATA = 5,
  parameter int unsigned SKID     = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
  input  logic [NUM_REGS*5-1:0]        in_regs,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [NUM_REGS*5-1:0]        out_regs,
  output logic [NUM_DATA*DATA_W-1:0]   out_data
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned REGS_W = NUM_REGS * REG_W;
  localparam int unsigned BUS_W  = NUM_DATA * DATA_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              accept, pop;
  logic              load_main, load_skid, move_skid;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [REGS_W-1:0] main_regs, skid_regs;
  logic [BUS_W-1:0]  main_data, skid_data;

  // A beat arriving on a flush edge is discarded even when handshaken.
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q != ST_EMPTY);
  assign pop       = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and load strobes
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d   = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Ready: registered with skid buffer, otherwise a combinational pass-through of out_ready
  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_FULL);
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = (state_q == ST_EMPTY) || out_ready;
    end
  endgenerate

  // Entry storage; flush clears control only, payload is don't-care while invalid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_ctrl <= '0;
      main_regs <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_regs <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_regs <= in_regs;
        main_data <= in_data;
      end else if (move_skid) begin
        main_ctrl <= skid_ctrl;
        main_regs <= skid_regs;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_regs <= in_regs;
        skid_data <= in_data;
      end
    end
  end

  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
  assign out_regs = main_regs;
  assign out_data = main_data;

endmodule
